frame_fifo: RTL and testbench
=============================

Name: frame_fifo

Overview:
- Parametrised, frame-aware successor to the single-clock byte FIFO used in the Ethernet datapath.
- Stores data words with an end-of-frame marker.
- The read side sees only committed (complete) frames.
- A frame being written can be discarded with rollback, and overflowing frames are dropped automatically.
- Sits between the MAC RX byte stream and the RTPS/UDP parser, so the parser never observes partial or corrupted frames.

Parameters:
- DATA_WIDTH, 8, width of one data word.
- DEPTH, 64, number of storage entries; power of two, at least 4. All DEPTH entries are usable.
- AFULL_THRESH, DEPTH-8, almost_full asserts when occupancy >= this value.
- PTR_WIDTH, $clog2(DEPTH), derived; pointers are PTR_WIDTH+1 bits wide.

Ports:
- clk, input, 1, clock; all logic on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- wr_en, input, 1, write strobe for din/wr_last.
- din, input, DATA_WIDTH, write data.
- wr_last, input, 1, qualified by wr_en; marks the final word of a frame and commits the frame.
- wr_drop, input, 1, discards the uncommitted frame in progress; independent of wr_en.
- full, output, 1, occupancy (including uncommitted words) == DEPTH.
- almost_full, output, 1, occupancy >= AFULL_THRESH.
- rd_en, input, 1, read strobe; advances the read pointer when !empty.
- dout, output, DATA_WIDTH, word at the read pointer (first-word fall-through, combinational from storage).
- dout_last, output, 1, end-of-frame flag stored with dout.
- empty, output, 1, no committed word available (rp == wp_commit).
- level, output, PTR_WIDTH+1, committed occupancy, wp_commit - rp, range 0..DEPTH.
- drop_pulse, output, 1, one-cycle pulse when a frame is discarded (by wr_drop or overflow).
- overflow, output, 1, sticky; set on any write attempted while full; cleared only by reset.

Behaviour:
- **Reset.** Asynchronous assert, synchronous-safe release.
  - Pointers wp, wp_commit, rp and the frame-bad flag reset to 0.
  - Outputs at reset: full=0, almost_full=0 (0 >= AFULL_THRESH false, given AFULL_THRESH > 0), empty=1, level=0, drop_pulse=0, overflow=0.
  - Storage is not reset; dout/dout_last are don't-care while empty.
- **Pointers.** All pointers are PTR_WIDTH+1 bits and wrap modulo 2*DEPTH.
  - Index = low PTR_WIDTH bits.
  - full when (wp - rp) == DEPTH; occupancy for almost_full = wp - rp.
- **Write, accepted case** (wr_en & !full & !bad): mem[wp] <= {wr_last, din}; wp <= wp+1.
  - If wr_last also set, wp_commit <= wp+1 in the same cycle.
  - The committed frame is visible to the read side (empty falls) on the next cycle: one-cycle write-to-read latency.
- **Write, overflow case** (wr_en & full):
  - Word is discarded; overflow <= 1; bad <= 1.
  - While bad, further words are discarded, with no storage write.
- **Frame end while bad** (wr_en & wr_last & bad, or a full-rejected wr_last word):
  - wp <= wp_commit (rollback); bad <= 0; drop_pulse for one cycle.
  - The next word starts a fresh frame.
- **wr_drop:**
  - wp <= wp_commit; bad <= 0; drop_pulse=1 for one cycle.
  - Any simultaneous wr_en word is discarded; drop wins over wr_last.
  - wr_drop with no frame in progress (wp == wp_commit, !bad): no pointer change, no drop_pulse.
- **Read:** rd_en & !empty advances rp by 1; dout/dout_last update combinationally to the new rp. rd_en while empty is ignored, with no error flag.
- **Simultaneous read and write:** both take effect in the same cycle.
  - full is evaluated on the pre-edge pointers, so a write while full is rejected even if a read occurs in the same cycle.
  - A write when not full is always accepted.
- **Rollback and reads:** rollback never moves wp below wp_commit, so the read side is unaffected by drops.
- **Oversized frame:** a frame that cannot fit even when the FIFO is otherwise empty (length > DEPTH) always overflows and is dropped; the FIFO does not deadlock.
- **Mid-frame reset:** all state is cleared, and a partial frame is lost without drop_pulse.
- **Implementation:** no combinational path from rd_en or wr_en to full or empty.

Test Plan:
- Reset, then write a 5-word frame 0x10..0x14 with wr_last on 0x14:
  - empty stays 1 until the cycle after the last write; then level=5.
  - Reading 5 words returns 0x10..0x14 with dout_last=1 only on 0x14; empty=1 afterwards.
- DEPTH=64: write 64 single-word frames with no reads:
  - full=1 after the 64th write; almost_full=1 from occupancy 56.
  - A 65th write sets overflow=1 and leaves level=64.
- Write 3 words without wr_last, then pulse wr_drop:
  - drop_pulse=1 for one cycle; level and empty are unchanged.
  - The next frame 0xA0,0xA1(last) reads back as exactly 0xA0,0xA1.
- With 60 committed words, write a 10-word frame:
  - Words beyond capacity are rejected; on the 10th (last) word, wp rolls back and drop_pulse fires.
  - level=60, overflow=1, and the next 2-word frame is accepted once 4 words have been read.
- Concurrent read/write at steady occupancy 32 for 200 cycles with random frame lengths 1..8:
  - Read data matches a scoreboard; pointer wrap past 2*DEPTH is exercised.
- Assert rst_n low asynchronously mid-frame, between clock edges:
  - Outputs go to reset values immediately (empty=1, level=0, overflow=0); no drop_pulse.

Source files
------------

// File: rtl/frame_fifo.sv
// rtl/frame_fifo.sv - frame-aware FIFO with commit, rollback and automatic overflow drop
//
// Purpose:
//   A single-clock FIFO that stores data words, each tagged with an end-of-frame flag.
//   The read side sees only complete (committed) frames. A frame that is still being
//   written can be discarded with wr_drop. A frame that overflows the storage is rolled
//   back automatically when its last word arrives.
//
// Ports:
//   clk, rst_n                 clock and asynchronous active-low reset
//   wr_en, din, wr_last        write strobe, data and end-of-frame marker (wr_last commits)
//   wr_drop                    discard the uncommitted frame in progress
//   full, almost_full          status on total occupancy (wp - rp), uncommitted words included
//   overflow                   sticky flag: a write was attempted while full
//   drop_pulse                 one-cycle pulse each time a frame is discarded
//   rd_en, dout, dout_last     first-word fall-through read port
//   empty, level               committed occupancy status (wp_commit - rp)
module frame_fifo #(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 64,
    parameter int AFULL_THRESH = DEPTH - 8,
    parameter int PTR_WIDTH    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  wr_last,
    input  logic                  wr_drop,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_last,
    output logic                  empty,
    output logic [PTR_WIDTH:0]    level,
    output logic                  drop_pulse,
    output logic                  overflow
);

    localparam logic [PTR_WIDTH:0] DEPTH_V = (PTR_WIDTH + 1)'(DEPTH);
    localparam logic [PTR_WIDTH:0] AFULL_V = (PTR_WIDTH + 1)'(AFULL_THRESH);

    logic [DATA_WIDTH:0] mem [DEPTH];

    // One extra pointer bit distinguishes full from empty, so all DEPTH entries are usable.
    logic [PTR_WIDTH:0] wp;
    logic [PTR_WIDTH:0] wp_commit;
    logic [PTR_WIDTH:0] rp;
    logic               bad;
    logic [PTR_WIDTH:0] occ;
    logic               in_progress;
    logic               wr_accept;
    logic [DATA_WIDTH:0] rd_word;

    // Status is decoded from registered pointers only, so rd_en/wr_en never reach full/empty.
    assign occ         = wp - rp;
    assign full        = (occ == DEPTH_V);
    assign almost_full = (occ >= AFULL_V);
    assign empty       = (rp == wp_commit);
    assign level       = wp_commit - rp;

    assign in_progress = (wp != wp_commit) || bad;
    assign wr_accept   = wr_en && !wr_drop && !full && !bad;

    assign rd_word   = mem[rp[PTR_WIDTH-1:0]];
    assign dout      = rd_word[DATA_WIDTH-1:0];
    assign dout_last = rd_word[DATA_WIDTH];

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wp[PTR_WIDTH-1:0]] <= {wr_last, din};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp         <= '0;
            wp_commit  <= '0;
            rp         <= '0;
            bad        <= 1'b0;
            drop_pulse <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            drop_pulse <= 1'b0;

            if (rd_en && !empty) begin
                rp <= rp + 1'b1;
            end

            if (wr_en && full) begin
                overflow <= 1'b1;
            end

            // Rollback only ever returns wp to wp_commit, so committed data is never touched.
            if (wr_drop) begin
                if (in_progress) begin
                    wp         <= wp_commit;
                    bad        <= 1'b0;
                    drop_pulse <= 1'b1;
                end
            end else if (wr_en) begin
                if (full || bad) begin
                    // Once a frame has lost a word it is poisoned until its last word arrives.
                    if (wr_last) begin
                        wp         <= wp_commit;
                        bad        <= 1'b0;
                        drop_pulse <= 1'b1;
                    end else begin
                        bad <= 1'b1;
                    end
                end else begin
                    wp <= wp + 1'b1;
                    if (wr_last) begin
                        wp_commit <= wp + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_frame_fifo.sv
// tb/tb_frame_fifo.sv - self-checking bench for frame_fifo
module tb_frame_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 64;
    localparam int AF    = DEPTH - 8;
    localparam int PW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [DW-1:0] din;
    logic          wr_last;
    logic          wr_drop;
    logic          full;
    logic          almost_full;
    logic          rd_en;
    logic [DW-1:0] dout;
    logic          dout_last;
    logic          empty;
    logic [PW:0]   level;
    logic          drop_pulse;
    logic          overflow;

    int passed = 0;
    int total  = 0;

    logic [DW:0] sb[$];
    logic [DW:0] pend[$];

    typedef struct {
        logic          we;
        logic [DW-1:0] d;
        logic          last;
        logic          drop;
        logic          re;
        logic          e_empty;
        logic [PW:0]   e_level;
        logic          e_drop;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    frame_fifo #(
        .DATA_WIDTH  (DW),
        .DEPTH       (DEPTH),
        .AFULL_THRESH(AF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .din        (din),
        .wr_last    (wr_last),
        .wr_drop    (wr_drop),
        .full       (full),
        .almost_full(almost_full),
        .rd_en      (rd_en),
        .dout       (dout),
        .dout_last  (dout_last),
        .empty      (empty),
        .level      (level),
        .drop_pulse (drop_pulse),
        .overflow   (overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic we, input logic [DW-1:0] d, input logic last,
                                 input logic drop, input logic re, input logic e_empty,
                                 input logic [PW:0] e_level, input logic e_drop);
        vec_t v;
        v.we = we; v.d = d; v.last = last; v.drop = drop; v.re = re;
        v.e_empty = e_empty; v.e_level = e_level; v.e_drop = e_drop;
        return v;
    endfunction

    // One clock of stimulus. Reads are checked against the scoreboard before the edge;
    // tracked writes are held in pend until their frame commits, then moved to sb.
    task automatic cyc(input logic we, input logic [DW-1:0] d, input logic last,
                       input logic drop, input logic re, input logic track);
        logic [DW:0] e;
        wr_en = we; din = d; wr_last = last; wr_drop = drop; rd_en = re;
        if (re && sb.size() > 0) begin
            e = sb.pop_front();
            check("rd_data", {23'b0, dout_last, dout}, {23'b0, e});
        end
        if (drop) begin
            pend.delete();
        end else if (we && track) begin
            pend.push_back({last, d});
            if (last) begin
                foreach (pend[i]) sb.push_back(pend[i]);
                pend.delete();
            end
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0; wr_last = 1'b0; wr_drop = 1'b0; rd_en = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wr_en = 1'b0; din = '0; wr_last = 1'b0; wr_drop = 1'b0; rd_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        pend.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] rd;
        int len;
        int cnt;

        // Reset state
        do_reset();
        check("rst_empty", empty, 1);
        check("rst_level", level, 0);
        check("rst_full", full, 0);
        check("rst_afull", almost_full, 0);
        check("rst_drop", drop_pulse, 0);
        check("rst_ovf", overflow, 0);

        // Table: 5-word frame, readback, then drop of a partial frame
        vecs.push_back(mkv(1, 8'h10, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mkv(1, 8'h11, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mkv(1, 8'h12, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mkv(1, 8'h13, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mkv(1, 8'h14, 1, 0, 0, 0, 5, 0));
        vecs.push_back(mkv(0, 8'h00, 0, 0, 1, 0, 4, 0));
        vecs.push_back(mkv(0, 8'h00, 0, 0, 1, 0, 3, 0));
        vecs.push_back(mkv(0, 8'h00, 0, 0, 1, 0, 2, 0));
        vecs.push_back(mkv(0, 8'h00, 0, 0, 1, 0, 1, 0));
        vecs.push_back(mkv(0, 8'h00, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mkv(1, 8'h30, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mkv(1, 8'h20, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mkv(1, 8'h21, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mkv(1, 8'h22, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mkv(0, 8'h00, 0, 1, 0, 0, 1, 1));
        vecs.push_back(mkv(0, 8'h00, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mkv(0, 8'h00, 0, 1, 0, 0, 1, 0));
        vecs.push_back(mkv(1, 8'hA0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mkv(1, 8'hA1, 1, 0, 0, 0, 3, 0));
        vecs.push_back(mkv(0, 8'h00, 0, 0, 1, 0, 2, 0));
        vecs.push_back(mkv(0, 8'h00, 0, 0, 1, 0, 1, 0));
        vecs.push_back(mkv(0, 8'h00, 0, 0, 1, 1, 0, 0));
        foreach (vecs[i]) begin
            cyc(vecs[i].we, vecs[i].d, vecs[i].last, vecs[i].drop, vecs[i].re, 1'b1);
            check($sformatf("tbl_empty_%0d", i), empty, vecs[i].e_empty);
            check($sformatf("tbl_level_%0d", i), level, vecs[i].e_level);
            check($sformatf("tbl_drop_%0d", i), drop_pulse, vecs[i].e_drop);
        end

        // Fill with 64 single-word frames, then one more
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b1, 8'(i), 1'b1, 1'b0, 1'b0, 1'b1);
            check($sformatf("fill_afull_%0d", i), almost_full, (i + 1 >= AF));
            check($sformatf("fill_full_%0d", i), full, (i == DEPTH - 1));
        end
        check("fill_level", level, DEPTH);
        check("fill_ovf_pre", overflow, 0);
        cyc(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0, 1'b0);
        check("ovf_set", overflow, 1);
        check("ovf_level", level, DEPTH);
        check("ovf_drop", drop_pulse, 1);
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        check("drain_empty", empty, 1);
        check("drain_ovf_sticky", overflow, 1);

        // 60 committed words, then a 10-word frame that overflows
        do_reset();
        for (int i = 0; i < 60; i++) cyc(1'b1, 8'(i + 100), (i == 59), 1'b0, 1'b0, 1'b1);
        check("big_level60", level, 60);
        for (int k = 0; k < 10; k++) begin
            cyc(1'b1, 8'(8'h80 + k), (k == 9), 1'b0, 1'b0, 1'b0);
            check($sformatf("big_drop_%0d", k), drop_pulse, (k == 9));
            if (k == 3) check("big_full", full, 1);
        end
        check("big_level_after", level, 60);
        check("big_ovf", overflow, 1);
        check("big_full_after", full, 0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 8'hC0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 8'hC1, 1'b1, 1'b0, 1'b0, 1'b1);
        check("big_level58", level, 58);
        check("big_next_drop", drop_pulse, 0);

        // Asynchronous reset mid-frame, between clock edges
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_empty", empty, 1);
        check("arst_level", level, 0);
        check("arst_ovf", overflow, 0);
        check("arst_drop", drop_pulse, 0);
        check("arst_full", full, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        pend.delete();
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("arst_drop_after", drop_pulse, 0);
        check("arst_empty_after", empty, 1);

        // Steady-state concurrent read/write around occupancy 32 with random frame lengths
        do_reset();
        for (int i = 0; i < 32; i++) begin
            rd = 8'($urandom);
            cyc(1'b1, rd, (i == 31), 1'b0, 1'b0, 1'b1);
        end
        check("steady_level32", level, 32);
        len = $urandom_range(1, 8);
        cnt = 0;
        for (int c = 0; c < 200; c++) begin
            rd = 8'($urandom);
            cyc(1'b1, rd, (cnt == len - 1), 1'b0, 1'b1, 1'b1);
            if (cnt == len - 1) begin
                len = $urandom_range(1, 8);
                cnt = 0;
            end else begin
                cnt++;
            end
        end
        for (int j = 0; j < 8 && cnt != 0; j++) begin
            rd = 8'($urandom);
            cyc(1'b1, rd, (cnt == len - 1), 1'b0, 1'b0, 1'b1);
            if (cnt == len - 1) cnt = 0; else cnt++;
        end
        for (int j = 0; j < 100 && sb.size() > 0; j++) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        check("steady_empty", empty, 1);
        check("steady_level0", level, 0);
        check("steady_ovf", overflow, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
